// File: rtl/uart_pkt_rx.sv
// 8N1 serial receiver that frames STX | payload | ETX packets and presents the payload
// on a valid/ready port, with start-glitch, stop-bit, framing, watchdog and overrun checks.
module uart_pkt_rx #(
  parameter int          CLKS_PER_BIT   = 46,
  parameter int          PKT_BYTES      = 8,
  parameter logic [7:0]  STX            = 8'h02,
  parameter logic [7:0]  ETX            = 8'h03,
  parameter int          TIMEOUT_CYCLES = 500000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_in,
  output logic [8*(PKT_BYTES-2)-1:0]   pkt_data,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic                         frame_err,
  output logic                         timeout_err,
  output logic                         overrun,
  output logic                         busy
);

  localparam int PW    = 8*(PKT_BYTES-2);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(PKT_BYTES);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PKT_BYTES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic             rx_meta_q, rx_s_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [IDX_W-1:0] idx_q;
  logic [WD_W-1:0]  wd_q;
  logic [PW-1:0]    staging_q;
  logic [PW-1:0]    pkt_data_q;
  logic             pkt_valid_q, frame_err_q, timeout_err_q, overrun_q;

  logic byte_done, pkt_complete;

  // A byte is accepted only when the stop bit samples high.
  assign byte_done    = (state_q == S_STOP) && (cnt_q == BIT_LAST) && rx_s_q;
  assign pkt_complete = byte_done && (idx_q == IDX_LAST) && (shift_q == ETX);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PKT_BYTES-2; i++) begin
      if (byte_done && idx_q == IDX_W'(i+1)) staging_q[i*8 +: 8] <= shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      idx_q         <= '0;
      wd_q          <= '0;
      pkt_data_q    <= '0;
      pkt_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            state_q <= S_IDLE;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (byte_done) begin
        if (idx_q == '0) begin
          if (shift_q == STX) idx_q <= IDX_W'(1);
          else                frame_err_q <= 1'b1;
        end else if (idx_q == IDX_LAST) begin
          idx_q <= '0;
          if (shift_q != ETX) frame_err_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end

      // Watchdog runs only between bytes of a packet in progress.
      if (idx_q == '0 || state_q != S_IDLE || !rx_s_q) begin
        wd_q <= '0;
      end else if (wd_q == WD_LAST) begin
        wd_q          <= '0;
        timeout_err_q <= 1'b1;
        idx_q         <= '0;
      end else begin
        wd_q <= wd_q + 1'b1;
      end

      if (pkt_complete) begin
        if (!pkt_valid_q || pkt_ready) begin
          pkt_data_q  <= staging_q;
          pkt_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (pkt_valid_q && pkt_ready) begin
        pkt_valid_q <= 1'b0;
      end
    end
  end

  assign pkt_data    = pkt_data_q;
  assign pkt_valid   = pkt_valid_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;
  assign busy        = (idx_q != '0) || (state_q != S_IDLE);

endmodule
